// File: rtl/grs_pkg.sv
// rtl/grs_pkg.sv - shared constants and FSM encoding for the Groestl permutation sequencer
package grs_pkg;

    localparam int GRS_STATE_W  = 1024;
    localparam int GRS_ROUND_W  = 4;
    localparam int GRS_P_ROUNDS = 14;

    typedef enum logic [1:0] {
        GRS_IDLE = 2'd0,
        GRS_RUN  = 2'd1,
        GRS_DONE = 2'd2
    } grs_fsm_e;

endpackage

// File: rtl/grs_perm_sequencer.sv
// rtl/grs_perm_sequencer.sv - iterative round sequencer for the external Groestl P round core
// Optional GRS_FEEDFORWARD_EN: out_data = final state XOR captured input state.
module grs_perm_sequencer
    import grs_pkg::*;
#(
    parameter int NUM_ROUNDS   = GRS_P_ROUNDS,
    parameter int PERM_LATENCY = 2,
    parameter int STATE_W      = GRS_STATE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [STATE_W-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [STATE_W-1:0]     out_data,
    output logic                   busy,
    output logic [GRS_ROUND_W-1:0] perm_round,
    output logic [STATE_W-1:0]     perm_in,
    input  logic [STATE_W-1:0]     perm_out
);

    localparam int WAIT_W = $clog2(PERM_LATENCY + 1);
    localparam logic [WAIT_W-1:0]      WAIT_LAST  = WAIT_W'(PERM_LATENCY);
    localparam logic [GRS_ROUND_W-1:0] ROUND_LAST = GRS_ROUND_W'(NUM_ROUNDS - 1);

    grs_fsm_e               fsm;
    logic [STATE_W-1:0]     state_q;
    logic [GRS_ROUND_W-1:0] round_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= GRS_IDLE;
            state_q     <= '0;
            round_q     <= '0;
            wait_q      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (fsm)
                GRS_IDLE: begin
                    if (in_valid) begin
                        state_q    <= in_data;
                        round_q    <= '0;
                        wait_q     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        fsm        <= GRS_RUN;
                    end
                end
                GRS_RUN: begin
                    // perm_out is only trusted in the last wait cycle of each round
                    if (wait_q == WAIT_LAST) begin
                        state_q <= perm_out;
                        wait_q  <= '0;
                        if (round_q == ROUND_LAST) begin
                            r_out_valid <= 1'b1;
                            fsm         <= GRS_DONE;
                        end else begin
                            round_q <= round_q + GRS_ROUND_W'(1);
                        end
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                GRS_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        fsm         <= GRS_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    fsm         <= GRS_IDLE;
                end
            endcase
        end
    end

`ifdef GRS_FEEDFORWARD_EN
    logic [STATE_W-1:0] hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (fsm == GRS_IDLE && in_valid) begin
            hold_q <= in_data;
        end
    end

    assign out_data = state_q ^ hold_q;
`else
    assign out_data = state_q;
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign perm_in    = state_q;
    assign perm_round = round_q;

endmodule

// File: tb/tb_grs_perm_sequencer.sv
// tb/tb_grs_perm_sequencer.sv - randomized self-checking bench with a pipelined stub round core
module tb_grs_perm_sequencer;

    localparam int NR  = 4;
    localparam int LAT = 3;
    localparam int SW  = 1024;
    localparam int JOB_EDGES = NR * (LAT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [3:0]    perm_round;
    logic [SW-1:0] out_data;
    logic [SW-1:0] perm_in;
    logic [SW-1:0] perm_out;

    int n_checks = 0;
    int n_fail   = 0;

    grs_perm_sequencer #(
        .NUM_ROUNDS  (NR),
        .PERM_LATENCY(LAT),
        .STATE_W     (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .perm_round(perm_round),
        .perm_in   (perm_in),
        .perm_out  (perm_out)
    );

    always #5 clk = ~clk;

    // Stub round: byte rotate, then mix in the round number and a constant pattern.
    function automatic logic [SW-1:0] stub_f(input logic [SW-1:0] x, input logic [3:0] r);
        logic [SW-1:0] pat;
        pat = {(SW/64){64'hA5C3_0F96_1E2D_3B4C}};
        return {x[SW-9:0], x[SW-1:SW-8]} ^ SW'(r) ^ pat;
    endfunction

    // Un-reset core pipeline: result appears LAT edges after sampling (sampling edge included).
    logic [SW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= stub_f(perm_in, perm_round);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign perm_out = pipe[LAT-1];

    function automatic logic [SW-1:0] model(input logic [SW-1:0] d);
        logic [SW-1:0] s;
        s = d;
        for (int r = 0; r < NR; r++) s = stub_f(s, 4'(r));
`ifdef GRS_FEEDFORWARD_EN
        s = s ^ d;
`endif
        return s;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] v;
        for (int i = 0; i < SW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed hi=%h lo=%h expected hi=%h lo=%h", tag,
                   obs[SW-1 -: 64], obs[63:0], exp[SW-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; leaves in_valid=1 with junk during the handshake edge.
    task automatic run_job(input string name, input logic [SW-1:0] d, input int bp);
        logic [SW-1:0] exp;
        logic [SW-1:0] held;
        int lat;
        bit round_ok;
        exp = model(d);
        chk({name, "_in_ready_before"}, SW'(in_ready), SW'(1));
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = rand_state();
        lat = 0;
        round_ok = 1'b1;
        while (!out_valid && lat < JOB_EDGES + 20) begin
            if (perm_round !== 4'(lat / (LAT + 1)) || busy !== 1'b1 || in_ready !== 1'b0)
                round_ok = 1'b0;
            step();
            lat++;
        end
        chk({name, "_round_sequence"}, SW'(round_ok), SW'(1));
        chk({name, "_latency"}, SW'(lat), SW'(JOB_EDGES));
        chk({name, "_out_data"}, out_data, exp);
        held = out_data;
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand_state();
            step();
            chk({name, "_bp_hold"}, {out_data, out_valid, in_ready, busy},
                {held, 1'b1, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_state();
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({name, "_after_handshake"}, SW'({out_valid, in_ready, busy}), SW'(3'b010));
    endtask

    initial begin
        logic [SW-1:0] ones;
        bit spurious;
        ones = '1;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_outputs", SW'({in_ready, out_valid, busy, perm_round}), SW'({1'b1, 1'b0, 1'b0, 4'd0}));
        chk("reset_perm_in", perm_in, '0);

        run_job("zero", '0, 0);
        run_job("ones", ones, 0);
        run_job("rand_bp", rand_state(), 10);
        run_job("b2b_a", rand_state(), 2);
        run_job("b2b_b", rand_state(), 0);

        in_valid = 1'b1;
        in_data  = rand_state();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_outputs", SW'({in_ready, out_valid, busy, perm_round}), SW'({1'b1, 1'b0, 1'b0, 4'd0}));
        spurious = 1'b0;
        for (int i = 0; i < JOB_EDGES + 5; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
            step();
        end
        chk("midreset_no_result", SW'(spurious), SW'(0));
        run_job("post_reset", rand_state(), 1);

        for (int k = 0; k < 3; k++) run_job("rand_loop", rand_state(), int'($urandom_range(0, 4)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
